parking_gate_ctrl: RTL and testbench
====================================

// Module: parking_gate_ctrl
// PURPOSE
//  Parametrised entry-gate controller for the car-park: password-gated entry with
//  configurable password width, entry timeout, wrong-attempt lockout and occupancy
//  tracking with a full flag. Sits between the lane sensors/keypad and the gate
//  actuator, LEDs and occupancy display. Successor to the fixed 2-bit controller.
// PARAMETERS
//  CAPACITY     16  max cars in lot; full asserted when occupancy==CAPACITY
//  PWD_W        4   password width in bits
//  WAIT_CYCLES  8   cycles in WAIT_PWD without pwd_valid before timeout to IDLE
//  MAX_TRIES    3   consecutive mismatches that force LOCKED
//  LOCK_CYCLES  64  cycles spent in LOCKED before returning to IDLE
//  BLINK_DIV    4   cycles per LED blink half-period (>=1)
// PORTS
//  clk              in   1        clock, all state on rising edge
//  reset_n          in   1        asynchronous, active-low reset
//  sensor_entrance  in   1        car present at gate
//  sensor_exit      in   1        car cleared gate (inside lot)
//  car_leave        in   1        1-cycle pulse: a car left by the exit lane
//  pwd_valid        in   1        1-cycle strobe, pwd_in valid
//  pwd_in           in   PWD_W    entered password
//  pwd_ref          in   PWD_W    configured password, quasi-static
//  gate_open        out  1        high in GRANTED only
//  green_led        out  1        blinks in GRANTED, else 0
//  red_led          out  1        1 in WAIT_PWD/LOCKED/IDLE&full; blinks in WRONG/STOP
//  full             out  1        occupancy==CAPACITY
//  lockout          out  1        high in LOCKED
//  occupancy        out  CNT_W    cars in lot, CNT_W=$clog2(CAPACITY+1)
//  state_o          out  3        current state encoding (debug/display)
// BEHAVIOUR
//  - Reset: state IDLE; occupancy, tries, timers, blink divider 0; all outputs 0.
//  - Outputs registered from state: one-cycle latency after state change.
//  - IDLE: entrance & !full -> WAIT_PWD (timer=0). entrance & full -> stay IDLE.
//  - WAIT_PWD: timer++ each cycle. pwd_valid&match -> GRANTED; pwd_valid&mismatch
//    -> WRONG, tries++. No pwd_valid and timer==WAIT_CYCLES-1 -> IDLE, tries=0.
//  - WRONG: pwd_valid&match -> GRANTED; mismatch -> tries++; if new tries==MAX_TRIES
//    -> LOCKED (lock timer=0), else stay WRONG. No timeout in WRONG.
//  - LOCKED: ignores pwd_valid and sensors; after LOCK_CYCLES cycles -> IDLE, tries=0.
//  - GRANTED: tries=0 on entry. entrance&exit -> STOP (tailgate). exit only -> IDLE
//    and occupancy+1 (one increment per GRANTED visit).
//  - STOP: pwd_valid&match -> GRANTED; mismatch ignored (no tries count).
//  - Invalid state encoding -> IDLE next cycle.
//  - occupancy: +1 on GRANTED exit, -1 on car_leave; both same cycle -> unchanged;
//    saturates at CAPACITY and 0 (car_leave at 0 ignored).
//  - Blink: free-running divider, toggles blink phase every BLINK_DIV cycles;
//    blinking LEDs follow phase, restart at phase 0 on state entry.
//  - Reset mid-operation: immediate return to reset values, occupancy lost.
// STRUCTURE
//  - Package parking_pkg: state typedef (IDLE=0,WAIT_PWD=1,WRONG=2,GRANTED=3,
//    STOP=4,LOCKED=5), CNT_W helper function.
//  - Sub-module parking_blink_div (BLINK_DIV counter, restart input, phase output).
//  - Top: state register, next-state logic, tries/timer counters, occupancy counter.
// TESTING
//  - Reset then entrance, pwd_valid with pwd_in==pwd_ref (0xA) on cycle 3 -> GRANTED,
//    gate_open 1 cycle later; exit -> IDLE, occupancy=1.
//  - Entrance, no pwd_valid for 8 cycles -> IDLE on 9th edge, tries=0, gate never open.
//  - Three mismatches (0x3,0x5,0x7) -> LOCKED, lockout=1 for 64 cycles; pwd match
//    during lock ignored; then IDLE.
//  - GRANTED with entrance&exit together -> STOP, red blinks period 2*BLINK_DIV;
//    matching pwd -> GRANTED, occupancy unchanged until exit.
//  - Fill to 16 -> full=1, entrance stays IDLE; car_leave -> 15, full=0;
//    GRANTED exit and car_leave same cycle -> occupancy unchanged.
//  - reset_n low mid-GRANTED with occupancy=5 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and helpers for the car-park entry gate.
// State encoding is visible on state_o, so values are fixed.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PWD = 3'd1,
    WRONG    = 3'd2,
    GRANTED  = 3'd3,
    STOP     = 3'd4,
    LOCKED   = 3'd5
  } state_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parking_blink_div.sv
// Blink phase generator: phase toggles every BLINK_DIV cycles.
// restart forces phase 0 so a newly entered state blinks from the start.
module parking_blink_div
  import parking_pkg::*;
#(
  parameter int BLINK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int DW = cnt_w(BLINK_DIV);

  logic [DW-1:0] cnt;

  // Free-running divider with synchronous restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == DW'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry-gate controller: password entry, timeout, lockout,
// tailgate stop and occupancy tracking with registered outputs.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 16,
  parameter int PWD_W       = 4,
  parameter int WAIT_CYCLES = 8,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 64,
  parameter int BLINK_DIV   = 4,
  localparam int CNT_W      = cnt_w(CAPACITY)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sensor_entrance,
  input  logic             sensor_exit,
  input  logic             car_leave,
  input  logic             pwd_valid,
  input  logic [PWD_W-1:0] pwd_in,
  input  logic [PWD_W-1:0] pwd_ref,
  output logic             gate_open,
  output logic             green_led,
  output logic             red_led,
  output logic             full,
  output logic             lockout,
  output logic [CNT_W-1:0] occupancy,
  output logic [2:0]       state_o
);

  localparam int TW = cnt_w(WAIT_CYCLES);
  localparam int LW = cnt_w(LOCK_CYCLES);
  localparam int RW = cnt_w(MAX_TRIES);

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   wait_cnt;
  logic [TW-1:0]   wait_cnt_nx;
  logic [LW-1:0]   lock_cnt;
  logic [LW-1:0]   lock_cnt_nx;
  logic [RW-1:0]   tries;
  logic [RW-1:0]   tries_nx;
  logic [RW-1:0]   tries_inc;
  logic [CNT_W-1:0] occ;
  logic            park_in;
  logic            match;
  logic            phase;

  assign match     = pwd_valid && (pwd_in == pwd_ref);
  assign tries_inc = tries + 1'b1;
  assign full      = (occ == CNT_W'(CAPACITY));
  assign occupancy = occ;

  // State, timers and attempt counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      lock_cnt <= '0;
      tries    <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      lock_cnt <= lock_cnt_nx;
      tries    <= tries_nx;
    end
  end

  // Next-state, timer and attempt logic.
  always_comb begin
    state_nx    = state;
    tries_nx    = tries;
    park_in     = 1'b0;
    wait_cnt_nx = '0;
    lock_cnt_nx = '0;
    if (state == WAIT_PWD) wait_cnt_nx = wait_cnt + 1'b1;
    if (state == LOCKED)   lock_cnt_nx = lock_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (sensor_entrance && !full) state_nx = WAIT_PWD;
      end
      WAIT_PWD: begin
        if (pwd_valid) begin
          if (match) begin
            state_nx = GRANTED;
          end else begin
            tries_nx = tries_inc;
            state_nx = (tries_inc >= RW'(MAX_TRIES)) ? LOCKED : WRONG;
          end
        end else if (wait_cnt == TW'(WAIT_CYCLES - 1)) begin
          state_nx = IDLE;
          tries_nx = '0;
        end
      end
      WRONG: begin
        if (pwd_valid) begin
          if (match) begin
            state_nx = GRANTED;
          end else begin
            tries_nx = tries_inc;
            if (tries_inc >= RW'(MAX_TRIES)) state_nx = LOCKED;
          end
        end
      end
      GRANTED: begin
        if (sensor_entrance && sensor_exit) begin
          state_nx = STOP;
        end else if (sensor_exit) begin
          state_nx = IDLE;
          park_in  = 1'b1;
        end
      end
      STOP: begin
        if (match) state_nx = GRANTED;
      end
      LOCKED: begin
        if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
          state_nx = IDLE;
          tries_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        tries_nx = '0;
      end
    endcase
    if (state_nx == GRANTED) tries_nx = '0;
  end

  // Occupancy: saturating up/down, simultaneous events cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ <= '0;
    end else if (park_in && !car_leave) begin
      if (!full) occ <= occ + 1'b1;
    end else if (car_leave && !park_in) begin
      if (occ != '0) occ <= occ - 1'b1;
    end
  end

  parking_blink_div #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (state_nx != state),
    .phase   (phase)
  );

  // Registered outputs decoded from the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_open <= 1'b0;
      green_led <= 1'b0;
      red_led   <= 1'b0;
      lockout   <= 1'b0;
      state_o   <= 3'd0;
    end else begin
      gate_open <= (state == GRANTED);
      green_led <= (state == GRANTED) && phase;
      red_led   <= (state == WAIT_PWD) || (state == LOCKED) ||
                   ((state == IDLE) && full) ||
                   (((state == WRONG) || (state == STOP)) && phase);
      lockout   <= (state == LOCKED);
      state_o   <= state;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural reference model.
module tb_parking_gate_ctrl;

  localparam int CAP   = 16;
  localparam int WAITC = 8;
  localparam int MAXT  = 3;
  localparam int LOCKC = 64;
  localparam int DIV   = 4;

  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_WRNG = 2;
  localparam int S_GRNT = 3;
  localparam int S_STOP = 4;
  localparam int S_LOCK = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic       car_leave;
  logic       pwd_valid;
  logic [3:0] pwd_in;
  logic [3:0] pwd_ref;
  logic       gate_open;
  logic       green_led;
  logic       red_led;
  logic       full;
  logic       lockout;
  logic [4:0] occupancy;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_err    = 0;

  int m_state, m_age, m_tries, m_occ;
  int e_gate, e_green, e_red, e_lock, e_st, e_occ, e_full;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .car_leave       (car_leave),
    .pwd_valid       (pwd_valid),
    .pwd_in          (pwd_in),
    .pwd_ref         (pwd_ref),
    .gate_open       (gate_open),
    .green_led       (green_led),
    .red_led         (red_led),
    .full            (full),
    .lockout         (lockout),
    .occupancy       (occupancy),
    .state_o         (state_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_age   = 0;
    m_tries = 0;
    m_occ   = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    int  ns, blink;
    bit  mt, inc;
    blink   = (m_age / DIV) % 2;
    e_gate  = (m_state == S_GRNT);
    e_green = (m_state == S_GRNT) && blink;
    e_red   = (m_state == S_WAIT) || (m_state == S_LOCK) ||
              (m_state == S_IDLE && m_occ == CAP) ||
              ((m_state == S_WRNG || m_state == S_STOP) && blink);
    e_lock  = (m_state == S_LOCK);
    e_st    = m_state;
    mt  = pwd_valid && (pwd_in == pwd_ref);
    ns  = m_state;
    inc = 0;
    case (m_state)
      S_IDLE:
        if (sensor_entrance && m_occ != CAP) ns = S_WAIT;
      S_WAIT:
        if (pwd_valid) begin
          if (mt) ns = S_GRNT;
          else begin
            m_tries++;
            ns = (m_tries >= MAXT) ? S_LOCK : S_WRNG;
          end
        end else if (m_age == WAITC - 1) begin
          ns = S_IDLE;
          m_tries = 0;
        end
      S_WRNG:
        if (pwd_valid) begin
          if (mt) ns = S_GRNT;
          else begin
            m_tries++;
            if (m_tries >= MAXT) ns = S_LOCK;
          end
        end
      S_LOCK:
        if (m_age == LOCKC - 1) begin
          ns = S_IDLE;
          m_tries = 0;
        end
      S_GRNT:
        if (sensor_entrance && sensor_exit) ns = S_STOP;
        else if (sensor_exit) begin
          ns  = S_IDLE;
          inc = 1;
        end
      S_STOP:
        if (mt) ns = S_GRNT;
      default: ns = S_IDLE;
    endcase
    if (ns == S_GRNT) m_tries = 0;
    if (inc && !car_leave) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
    else if (car_leave && !inc) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
    m_age   = (ns != m_state) ? 0 : m_age + 1;
    m_state = ns;
    e_occ  = m_occ;
    e_full = (m_occ == CAP);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gate_open", gate_open, e_gate);
    chk("green_led", green_led, e_green);
    chk("red_led", red_led, e_red);
    chk("lockout", lockout, e_lock);
    chk("state_o", state_o, e_st);
    chk("occupancy", occupancy, e_occ);
    chk("full", full, e_full);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gate"}, gate_open, 0);
    chk({tag, "_green"}, green_led, 0);
    chk({tag, "_red"}, red_led, 0);
    chk({tag, "_lock"}, lockout, 0);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_full"}, full, 0);
  endtask

  task automatic admit();
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    pwd_valid = 1'b1;
    pwd_in    = pwd_ref;
    step();
    pwd_valid   = 1'b0;
    sensor_exit = 1'b1;
    step();
    sensor_exit = 1'b0;
  endtask

  initial begin
    int occ_before;
    reset_n         = 1'b0;
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    car_leave       = 1'b0;
    pwd_valid       = 1'b0;
    pwd_in          = 4'h0;
    pwd_ref         = 4'hA;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Correct password on cycle 3, then drive in.
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    step();
    pwd_valid = 1'b1;
    pwd_in    = 4'hA;
    step();
    pwd_valid = 1'b0;
    step();
    chk("t1_gate_open", gate_open, 1);
    sensor_exit = 1'b1;
    step();
    sensor_exit = 1'b0;
    step();
    chk("t1_occ", occupancy, 1);
    chk("t1_idle", state_o, S_IDLE);

    // Timeout with no password.
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    repeat (WAITC) step();
    step();
    chk("t2_idle", state_o, S_IDLE);

    // Three wrong codes, then lockout ignoring a good code.
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    pwd_valid = 1'b1;
    pwd_in = 4'h3;
    step();
    pwd_in = 4'h5;
    step();
    pwd_in = 4'h7;
    step();
    pwd_in = 4'hA;
    step();
    chk("t3_lockout", lockout, 1);
    step();
    pwd_valid = 1'b0;
    repeat (LOCKC) step();
    chk("t3_unlocked", lockout, 0);
    chk("t3_idle", state_o, S_IDLE);

    // Tailgate stop, blink, re-grant.
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    pwd_valid = 1'b1;
    step();
    pwd_valid = 1'b0;
    occ_before = m_occ;
    sensor_entrance = 1'b1;
    sensor_exit     = 1'b1;
    step();
    sensor_entrance = 1'b0;
    sensor_exit     = 1'b0;
    repeat (4 * DIV) step();
    chk("t4_stop", state_o, S_STOP);
    pwd_valid = 1'b1;
    step();
    pwd_valid = 1'b0;
    step();
    chk("t4_occ_hold", occupancy, occ_before);
    sensor_exit = 1'b1;
    step();
    sensor_exit = 1'b0;
    step();
    chk("t4_occ_inc", occupancy, occ_before + 1);

    // Fill the lot, refuse entry, free a space.
    for (int i = 0; i < 20 && m_occ < CAP; i++) admit();
    step();
    chk("t5_full", full, 1);
    chk("t5_red_full", red_led, 1);
    sensor_entrance = 1'b1;
    step();
    step();
    chk("t5_refuse", state_o, S_IDLE);
    sensor_entrance = 1'b0;
    car_leave = 1'b1;
    step();
    car_leave = 1'b0;
    chk("t5_occ15", occupancy, 15);
    chk("t5_notfull", full, 0);
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    pwd_valid = 1'b1;
    step();
    pwd_valid   = 1'b0;
    sensor_exit = 1'b1;
    car_leave   = 1'b1;
    step();
    sensor_exit = 1'b0;
    car_leave   = 1'b0;
    chk("t5_cancel", occupancy, 15);

    // Async reset while granted with five cars inside.
    car_leave = 1'b1;
    repeat (10) step();
    car_leave = 1'b0;
    chk("t6_occ5", occupancy, 5);
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
    pwd_valid = 1'b1;
    step();
    pwd_valid = 1'b0;
    step();
    chk("t6_granted", gate_open, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      sensor_entrance = ($urandom % 3) == 0;
      sensor_exit     = ($urandom % 4) == 0;
      car_leave       = ($urandom % 8) == 0;
      pwd_valid       = ($urandom % 3) == 0;
      pwd_in = ($urandom % 2) ? pwd_ref : 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
